// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit for the execute stage: one result bit per cycle,
// stalling the pipeline through Busy until the sign-corrected result is registered.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} stateT;

  stateT              stateReg, stateNext;
  logic [CW-1:0]      countReg;
  logic               opDivReg;
  logic               negQReg, negRReg, divZeroReg;
  logic [WIDTH-1:0]   aReg, bReg, loReg, rawOp1Reg;
  logic [WIDTH:0]     hiReg;
  logic [WIDTH-1:0]   result1Reg, result2Reg;

  // Operand conditioning at the start edge (signed ops use magnitudes)
  logic               isSigned, neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;

  // One iteration of the shared datapath
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic               divFits;
  logic [WIDTH:0]     hiNext;
  logic [WIDTH-1:0]   loNext;
  logic [2*WIDTH-1:0] prodMag, prodFix;
  logic [WIDTH-1:0]   quotFix, remFix, fin1, fin2;
  logic               lastIter;

  assign isSigned = ~MCycleOp[0];
  assign neg1     = isSigned & Operand1[WIDTH-1];
  assign neg2     = isSigned & Operand2[WIDTH-1];
  assign abs1     = neg1 ? -Operand1 : Operand1;
  assign abs2     = neg2 ? -Operand2 : Operand2;
  assign lastIter = (countReg == CW'(WIDTH - 1));

  always_comb begin
    mulSum   = hiReg + (loReg[0] ? {1'b0, aReg} : '0);
    divShift = {hiReg[WIDTH-1:0], loReg[WIDTH-1]};
    divFits  = (divShift >= {1'b0, bReg});
    divDiff  = divShift - {1'b0, bReg};
    hiNext   = hiReg;
    loNext   = loReg;
    if (!opDivReg) begin
      // hi:lo is the running product; the multiplier shifts out of lo
      hiNext = {1'b0, mulSum[WIDTH:1]};
      loNext = {mulSum[0], loReg[WIDTH-1:1]};
    end else if (divFits) begin
      hiNext = divDiff;
      loNext = {loReg[WIDTH-2:0], 1'b1};
    end else begin
      hiNext = divShift;
      loNext = {loReg[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prodMag = {hiNext[WIDTH-1:0], loNext};
    prodFix = negQReg ? -prodMag : prodMag;
    quotFix = negQReg ? -loNext : loNext;
    remFix  = negRReg ? -hiNext[WIDTH-1:0] : hiNext[WIDTH-1:0];
    fin1    = prodFix[WIDTH-1:0];
    fin2    = prodFix[2*WIDTH-1:WIDTH];
    if (opDivReg) begin
      fin1 = divZeroReg ? '1 : quotFix;
      fin2 = divZeroReg ? rawOp1Reg : remFix;
    end
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE:      if (Start) stateNext = COMPUTING;
      COMPUTING: if (lastIter) stateNext = DONE;
      DONE:      stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      result1Reg <= '0;
      result2Reg <= '0;
    end else begin
      stateReg <= stateNext;
      unique case (stateReg)
        IDLE: if (Start) begin
          opDivReg   <= MCycleOp[1];
          aReg       <= abs1;
          bReg       <= MCycleOp[1] ? abs2 : abs2;
          loReg      <= MCycleOp[1] ? abs1 : abs2;
          hiReg      <= '0;
          negQReg    <= neg1 ^ neg2;
          negRReg    <= neg1;
          divZeroReg <= (Operand2 == '0);
          rawOp1Reg  <= Operand1;
          countReg   <= '0;
        end
        COMPUTING: begin
          hiReg    <= hiNext;
          loReg    <= loNext;
          countReg <= countReg + 1'b1;
          if (lastIter) begin
            result1Reg <= fin1;
            result2Reg <= fin2;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy    = RESETn & (((stateReg == IDLE) & Start) | (stateReg == COMPUTING));
  assign Result1 = result1Reg;
  assign Result2 = result2Reg;

endmodule
